// File: rtl/pheap_root_pkg.sv
// pheap shared types: key/value, heap entry, opcodes and priority compares.
// Used by the root controller and by the leq levels below it.
package pheapTypes;

    localparam int KEY_W = 8;
    localparam int VAL_W = 8;
    localparam int CAP_W = 8;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] val;
    } kv_t;

    typedef struct packed {
        logic             active;
        logic [CAP_W-1:0] capacity;
        kv_t              kv;
    } entry_t;

    typedef enum logic [1:0] {
        NOP     = 2'd0,
        ENQ     = 2'd1,
        DEQ     = 2'd2,
        ENQ_DEQ = 2'd3
    } opcode_t;

    typedef enum logic {
        NOT_DONE = 1'b0,
        DONE     = 1'b1
    } done_t;

    localparam kv_t              KV_EMPTY    = '0;
    localparam entry_t           ENTRY_EMPTY = '0;
    localparam logic [CAP_W-1:0] CAP_ONE     = 1;

    // Unsigned key compare, greater key = higher priority.
    function automatic logic cmp_kv_gt(input kv_t a, input kv_t b);
        return a.key > b.key;
    endfunction

    // A key beats an empty slot unconditionally.
    function automatic logic cmp_kv_entry_gt(input kv_t a, input entry_t e);
        return !e.active || (a.key > e.kv.key);
    endfunction

    // Inactive entries lose to any active one.
    function automatic logic cmp_entry_entry_gt(input entry_t a, input entry_t b);
        return a.active && (!b.active || (a.kv.key > b.kv.key));
    endfunction

endpackage

// File: rtl/pheap_root_eval.sv
// pheap root evaluation: next root, response and the follow-on level-2 op.
// Purely combinational; the caller decides when the result is committed.
module pheap_root_eval
    import pheapTypes::*;
(
    input  entry_t  root,
    input  kv_t     in_reg,
    input  opcode_t op_reg,
    input  entry_t  rBotL,
    input  entry_t  rBotR,
    output entry_t  root_nxt,
    output logic    rsp_valid,
    output kv_t     rsp_kv,
    output logic    err,
    output opcode_t op2,
    output kv_t     kv2,
    output logic    startPos2,
    output logic    descend
);

    logic   big_r;
    logic   cap_r;
    entry_t big;
    logic   in_ge_kids;

    // Larger child (left on tie), roomier child (left on tie).
    always_comb begin
        big_r      = cmp_entry_entry_gt(rBotR, rBotL);
        cap_r      = rBotR.capacity > rBotL.capacity;
        big        = big_r ? rBotR : rBotL;
        in_ge_kids = !(rBotL.active && cmp_kv_gt(rBotL.kv, in_reg)) &&
                     !(rBotR.active && cmp_kv_gt(rBotR.kv, in_reg));
    end

    // Per-opcode result; error cases leave the root untouched.
    always_comb begin
        root_nxt  = root;
        rsp_valid = 1'b0;
        rsp_kv    = KV_EMPTY;
        err       = 1'b0;
        op2       = NOP;
        kv2       = KV_EMPTY;
        startPos2 = 1'b0;
        descend   = 1'b0;
        unique case (op_reg)
            ENQ: begin
                if (root.capacity == '0) begin
                    err = 1'b1;
                end else if (!root.active) begin
                    root_nxt.active   = 1'b1;
                    root_nxt.capacity = root.capacity - CAP_ONE;
                    root_nxt.kv       = in_reg;
                end else begin
                    root_nxt.capacity = root.capacity - CAP_ONE;
                    if (cmp_kv_gt(in_reg, root.kv)) begin
                        root_nxt.kv = in_reg;
                        kv2         = root.kv;
                    end else begin
                        kv2 = in_reg;
                    end
                    op2       = ENQ;
                    startPos2 = cap_r;
                    descend   = 1'b1;
                end
            end
            DEQ: begin
                rsp_valid = 1'b1;
                if (!root.active) begin
                    err = 1'b1;
                end else begin
                    rsp_kv            = root.kv;
                    root_nxt.capacity = root.capacity + CAP_ONE;
                    if (!rBotL.active && !rBotR.active) begin
                        root_nxt.active = 1'b0;
                        root_nxt.kv     = KV_EMPTY;
                    end else begin
                        root_nxt.kv = big.kv;
                        op2         = DEQ;
                        startPos2   = big_r;
                        descend     = 1'b1;
                    end
                end
            end
            ENQ_DEQ: begin
                rsp_valid = 1'b1;
                if (!root.active || !cmp_kv_gt(root.kv, in_reg)) begin
                    rsp_kv = in_reg;
                end else begin
                    rsp_kv = root.kv;
                    if (in_ge_kids) begin
                        root_nxt.kv = in_reg;
                    end else begin
                        root_nxt.kv = big.kv;
                        op2         = ENQ_DEQ;
                        kv2         = in_reg;
                        startPos2   = big_r;
                        descend     = 1'b1;
                    end
                end
            end
            default: begin
                root_nxt = root;
            end
        endcase
    end

endmodule

// File: rtl/pheap_root.sv
// pheap level-1 controller: root register, request FSM, level-2 issue.
// Optional PHEAP_OCC_EN adds count/full/empty occupancy outputs.
module pheap_root
    import pheapTypes::*;
#(
    parameter int NLEVELS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  opcode_t          req_op,
    input  kv_t              req_kv,
    output logic             rsp_valid,
    output kv_t              rsp_kv,
    output logic             err,
    output logic             raddrBot,
    input  entry_t           rBotL,
    input  entry_t           rBotR,
    output logic             start2,
    output opcode_t          op2,
    output kv_t              kv2,
    output logic             startPos2,
    input  logic             active2
`ifdef PHEAP_OCC_EN
    ,
    output logic [NLEVELS:0] count,
    output logic             full,
    output logic             empty
`endif
);

    localparam logic [CAP_W-1:0] CAP_FULL = CAP_W'((1 << NLEVELS) - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EVAL = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0] state;
    entry_t     root;
    opcode_t    op_reg;
    kv_t        in_reg;
    opcode_t    op2_q;
    kv_t        kv2_q;
    logic       pos2_q;

    entry_t     ev_root;
    logic       ev_rsp_valid;
    kv_t        ev_rsp_kv;
    logic       ev_err;
    opcode_t    ev_op2;
    kv_t        ev_kv2;
    logic       ev_pos2;
    logic       ev_descend;

    pheap_root_eval u_eval (
        .root      (root),
        .in_reg    (in_reg),
        .op_reg    (op_reg),
        .rBotL     (rBotL),
        .rBotR     (rBotR),
        .root_nxt  (ev_root),
        .rsp_valid (ev_rsp_valid),
        .rsp_kv    (ev_rsp_kv),
        .err       (ev_err),
        .op2       (ev_op2),
        .kv2       (ev_kv2),
        .startPos2 (ev_pos2),
        .descend   (ev_descend)
    );

    // Request FSM, root commit in EVAL, downstream capture on stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            root.active   <= 1'b0;
            root.capacity <= CAP_FULL;
            root.kv       <= KV_EMPTY;
            op_reg        <= NOP;
            in_reg        <= KV_EMPTY;
            op2_q         <= NOP;
            kv2_q         <= KV_EMPTY;
            pos2_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_op != NOP) begin
                        op_reg <= req_op;
                        in_reg <= req_kv;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    root <= ev_root;
                    if (ev_descend && active2) begin
                        op2_q  <= ev_op2;
                        kv2_q  <= ev_kv2;
                        pos2_q <= ev_pos2;
                        state  <= HOLD;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!active2) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response and downstream drive; idle values outside EVAL/HOLD.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = 1'b0;
        rsp_kv    = KV_EMPTY;
        err       = 1'b0;
        start2    = 1'b0;
        op2       = NOP;
        kv2       = KV_EMPTY;
        startPos2 = 1'b0;
        if (state == EVAL) begin
            rsp_valid = ev_rsp_valid;
            rsp_kv    = ev_rsp_kv;
            err       = ev_err;
            if (ev_descend && !active2) begin
                start2    = 1'b1;
                op2       = ev_op2;
                kv2       = ev_kv2;
                startPos2 = ev_pos2;
            end
        end else if (state == HOLD) begin
            start2    = !active2;
            op2       = op2_q;
            kv2       = kv2_q;
            startPos2 = pos2_q;
        end
    end

    assign raddrBot = 1'b0;

`ifdef PHEAP_OCC_EN
    // Occupancy follows the root register directly.
    always_comb begin
        count = (NLEVELS+1)'(CAP_FULL - root.capacity);
        full  = (root.capacity == '0);
        empty = !root.active;
    end
`endif

endmodule

// File: tb/tb_pheap_root.sv
// pheap_root directed bench: children driven by hand, hand-computed results.
// Covers empty/full errors, ENQ/DEQ/ENQ_DEQ paths, stall and async reset.
module tb_pheap_root;
    import pheapTypes::*;

    logic    clk;
    logic    rst;
    logic    req_valid;
    logic    req_ready;
    opcode_t req_op;
    kv_t     req_kv;
    logic    rsp_valid;
    kv_t     rsp_kv;
    logic    err;
    logic    raddrBot;
    entry_t  rBotL;
    entry_t  rBotR;
    logic    start2;
    opcode_t op2;
    kv_t     kv2;
    logic    startPos2;
    logic    active2;
`ifdef PHEAP_OCC_EN
    logic [4:0] count;
    logic       full;
    logic       empty;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_start;

    pheap_root #(.NLEVELS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_kv    (req_kv),
        .rsp_valid (rsp_valid),
        .rsp_kv    (rsp_kv),
        .err       (err),
        .raddrBot  (raddrBot),
        .rBotL     (rBotL),
        .rBotR     (rBotR),
        .start2    (start2),
        .op2       (op2),
        .kv2       (kv2),
        .startPos2 (startPos2),
        .active2   (active2)
`ifdef PHEAP_OCC_EN
        ,
        .count     (count),
        .full      (full),
        .empty     (empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic kv_t mk(input logic [7:0] k);
        kv_t r;
        r.key = k;
        r.val = k ^ 8'hA5;
        return r;
    endfunction

    function automatic entry_t ent(input logic a, input logic [7:0] c,
                                   input logic [7:0] k);
        entry_t e;
        e.active   = a;
        e.capacity = c;
        e.kv       = a ? mk(k) : KV_EMPTY;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = 1'b0;
        req_op    = NOP;
        req_kv    = KV_EMPTY;
        active2   = 1'b0;
        rBotL     = ent(1'b0, 8'd7, 8'd0);
        rBotR     = ent(1'b0, 8'd7, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Starts at an IDLE negedge, returns at the EVAL negedge.
    task automatic issue(input opcode_t op, input logic [7:0] k);
        req_valid = 1'b1;
        req_op    = op;
        req_kv    = mk(k);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = NOP;
        req_kv    = KV_EMPTY;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // reset state and DEQ on empty heap
        do_reset();
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_kv", rsp_kv, KV_EMPTY);
        chk("rst_err", err, 0);
        chk("rst_start2", start2, 0);
        chk("rst_op2", op2, NOP);
        chk("rst_kv2", kv2, KV_EMPTY);
        chk("rst_pos2", startPos2, 0);
        chk("raddr", raddrBot, 0);
        chk("rst_active", dut.root.active, 0);
        chk("rst_cap", dut.root.capacity, 15);
`ifdef PHEAP_OCC_EN
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
`endif
        issue(DEQ, 8'd0);
        chk("deq_e_err", err, 1);
        chk("deq_e_rv", rsp_valid, 1);
        chk("deq_e_kv", rsp_kv, KV_EMPTY);
        chk("deq_e_st", start2, 0);
        step();
        chk("deq_e_act", dut.root.active, 0);
        chk("deq_e_cap", dut.root.capacity, 15);

        // ENQ 5, ENQ 9, DEQ
        issue(ENQ, 8'd5);
        chk("enq5_st", start2, 0);
        chk("enq5_rv", rsp_valid, 0);
        chk("enq5_err", err, 0);
        step();
        chk("enq5_kv", dut.root.kv, mk(8'd5));
        chk("enq5_act", dut.root.active, 1);
        chk("enq5_cap", dut.root.capacity, 14);
        issue(ENQ, 8'd9);
        chk("enq9_st", start2, 1);
        chk("enq9_op2", op2, ENQ);
        chk("enq9_kv2", kv2, mk(8'd5));
        chk("enq9_pos", startPos2, 0);
        step();
        chk("enq9_kv", dut.root.kv, mk(8'd9));
        chk("enq9_cap", dut.root.capacity, 13);
        rBotL = ent(1'b1, 8'd6, 8'd5);
        issue(DEQ, 8'd0);
        chk("deq9_rv", rsp_valid, 1);
        chk("deq9_kv", rsp_kv, mk(8'd9));
        chk("deq9_st", start2, 1);
        chk("deq9_op2", op2, DEQ);
        chk("deq9_pos", startPos2, 0);
        step();
        chk("deq9_root", dut.root.kv, mk(8'd5));
        chk("deq9_cap", dut.root.capacity, 14);

        // ENQ_DEQ paths and child selection
        do_reset();
        issue(ENQ, 8'd9);
        step();
        rBotL = ent(1'b1, 8'd6, 8'd7);
        rBotR = ent(1'b1, 8'd6, 8'd4);
        issue(ENQ_DEQ, 8'd10);
        chk("ed10_rv", rsp_valid, 1);
        chk("ed10_kv", rsp_kv, mk(8'd10));
        chk("ed10_st", start2, 0);
        step();
        chk("ed10_root", dut.root.kv, mk(8'd9));
        issue(ENQ_DEQ, 8'd3);
        chk("ed3_kv", rsp_kv, mk(8'd9));
        chk("ed3_st", start2, 1);
        chk("ed3_op2", op2, ENQ_DEQ);
        chk("ed3_kv2", kv2, mk(8'd3));
        chk("ed3_pos", startPos2, 0);
        step();
        chk("ed3_root", dut.root.kv, mk(8'd7));
        chk("ed3_cap", dut.root.capacity, 14);
        rBotL = ent(1'b1, 8'd6, 8'd2);
        rBotR = ent(1'b1, 8'd6, 8'd4);
        issue(ENQ_DEQ, 8'd5);
        chk("ed5_kv", rsp_kv, mk(8'd7));
        chk("ed5_st", start2, 0);
        step();
        chk("ed5_root", dut.root.kv, mk(8'd5));
        rBotL = ent(1'b1, 8'd5, 8'd2);
        rBotR = ent(1'b1, 8'd6, 8'd4);
        issue(ENQ, 8'd1);
        chk("enq1_st", start2, 1);
        chk("enq1_kv2", kv2, mk(8'd1));
        chk("enq1_pos", startPos2, 1);
        step();
        chk("enq1_root", dut.root.kv, mk(8'd5));
        chk("enq1_cap", dut.root.capacity, 13);
        issue(DEQ, 8'd0);
        chk("deqR_kv", rsp_kv, mk(8'd5));
        chk("deqR_op2", op2, DEQ);
        chk("deqR_pos", startPos2, 1);
        step();
        chk("deqR_root", dut.root.kv, mk(8'd4));
        chk("deqR_cap", dut.root.capacity, 14);
        rBotL = ent(1'b0, 8'd7, 8'd0);
        rBotR = ent(1'b0, 8'd7, 8'd0);
        issue(DEQ, 8'd0);
        chk("deqL_kv", rsp_kv, mk(8'd4));
        chk("deqL_st", start2, 0);
        step();
        chk("deqL_act", dut.root.active, 0);
        chk("deqL_cap", dut.root.capacity, 15);

        // fill to capacity, then ENQ while full
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            issue(ENQ, 8'(i));
            step();
        end
        chk("fill_cap", dut.root.capacity, 0);
        chk("fill_root", dut.root.kv, mk(8'd15));
`ifdef PHEAP_OCC_EN
        chk("fill_count", count, 15);
        chk("fill_full", full, 1);
`endif
        issue(ENQ, 8'd20);
        chk("full_err", err, 1);
        chk("full_st", start2, 0);
        chk("full_rv", rsp_valid, 0);
        step();
        chk("full_cap", dut.root.capacity, 0);
        chk("full_root", dut.root.kv, mk(8'd15));

        // level-2 busy: HOLD until active2 drops
        do_reset();
        issue(ENQ, 8'd5);
        step();
        active2 = 1'b1;
        issue(ENQ, 8'd9);
        chk("hold_e_st", start2, 0);
        chk("hold_e_rdy", req_ready, 0);
        chk("hold_e_rv", rsp_valid, 0);
        step();
        chk("hold1_st", start2, 0);
        chk("hold1_rdy", req_ready, 0);
        chk("hold_root", dut.root.kv, mk(8'd9));
        step();
        chk("hold2_st", start2, 0);
        active2 = 1'b0;
        #1;
        chk("hold_go_st", start2, 1);
        chk("hold_go_op2", op2, ENQ);
        chk("hold_go_kv2", kv2, mk(8'd5));
        chk("hold_go_pos", startPos2, 0);
        chk("hold_go_rdy", req_ready, 0);
        n_start = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_start += int'(start2);
        end
        chk("hold_once", n_start, 0);
        chk("hold_rdy", req_ready, 1);

        // async reset in the middle of EVAL
        do_reset();
        issue(ENQ, 8'd5);
        step();
        issue(ENQ, 8'd9);
        chk("mid_st_pre", start2, 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_st", start2, 0);
        chk("mid_rdy", req_ready, 1);
        chk("mid_op2", op2, NOP);
        chk("mid_act", dut.root.active, 0);
        chk("mid_cap", dut.root.capacity, 15);
        step();
        rst = 1'b1;
        n_start = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_start += int'(start2);
        end
        chk("mid_nostart", n_start, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
